// File: rtl/scv_pkg.sv
// Shared types and widths for the cartridge-slot bus master.
//   bus_state_t : external bus cycle phases (IDLE, T1, T2, TW, T3)
//   *_W         : address, data, wait-count and bank-select widths
package scv_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned WAIT_W = 2;
  localparam int unsigned PC_W   = 2;

  typedef enum logic [2:0] {
    IDLE,
    T1,
    T2,
    TW,
    T3
  } bus_state_t;

endpackage

// File: rtl/cart_bus_master.sv
// Cartridge-slot bus initiator: turns one CPU request into a T1/T2/TW*/T3
// bus cycle paced by CE, and sequences the PC[6:5] bank-select bits so they
// only change while the bus is idle.
// Ports:
//   CLK, RESB                 clock, async active-low reset
//   CE                        T-state enable
//   WAIT_N                    wait states, sampled on entry to T2
//   REQ/REQ_WR/REQ_A/REQ_D    CPU request; ACK/RD_DATA completion and read data
//   PC_WR/PC_D                bank-select write strobe and value; PC output
//   A/DB_O/DB_OE/DB_I         slot address, data out/enable, data in
//   RDB/WRB/CSB               active-low read, write and chip-select strobes
module cart_bus_master
  import scv_pkg::*;
(
  input  logic              CLK,
  input  logic              RESB,
  input  logic              CE,
  input  logic [WAIT_W-1:0] WAIT_N,
  input  logic              REQ,
  input  logic              REQ_WR,
  input  logic [ADDR_W-1:0] REQ_A,
  input  logic [DATA_W-1:0] REQ_D,
  output logic              ACK,
  output logic [DATA_W-1:0] RD_DATA,
  input  logic              PC_WR,
  input  logic [PC_W-1:0]   PC_D,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] DB_O,
  output logic              DB_OE,
  input  logic [DATA_W-1:0] DB_I,
  output logic              RDB,
  output logic              WRB,
  output logic              CSB,
  output logic [6:5]        PC
);

  bus_state_t        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              oe_q, oe_d;
  logic              rdb_q, rdb_d;
  logic              wrb_q, wrb_d;
  logic              csb_q, csb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              t3_hit_q, t3_hit_d;
  logic              ack_q, ack_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   pend_q, pend_d;
  logic              pend_v_q, pend_v_d;

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    a_d      = a_q;
    dout_d   = dout_q;
    oe_d     = oe_q;
    rdb_d    = rdb_q;
    wrb_d    = wrb_q;
    csb_d    = csb_q;
    rdata_d  = rdata_q;
    t3_hit_d = 1'b0;
    ack_d    = t3_hit_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;

    if (CE) begin
      case (state_q)
        IDLE: begin
          if (REQ) begin
            state_d = T1;
            wr_d    = REQ_WR;
            a_d     = REQ_A;
            csb_d   = 1'b0;
            oe_d    = REQ_WR;
            if (REQ_WR) dout_d = REQ_D;
          end
        end
        T1: begin
          state_d = T2;
          cnt_d   = WAIT_N;
          rdb_d   = wr_q;
          wrb_d   = ~wr_q;
        end
        T2, TW: begin
          if (cnt_q == 2'd0) begin
            state_d  = T3;
            rdb_d    = 1'b1;
            wrb_d    = 1'b1;
            t3_hit_d = 1'b1;
            // RDB is still low at this edge, so DB_I is valid here
            if (!wr_q) rdata_d = DB_I;
          end else begin
            state_d = TW;
            cnt_d   = cnt_q - 2'd1;
          end
        end
        T3: begin
          state_d = IDLE;
          csb_d   = 1'b1;
          oe_d    = 1'b0;
        end
        default: begin
          state_d = IDLE;
          csb_d   = 1'b1;
          rdb_d   = 1'b1;
          wrb_d   = 1'b1;
          oe_d    = 1'b0;
        end
      endcase
    end

    // Bank select: direct update only while idle and not starting a cycle;
    // otherwise park the value and apply it on the edge back into IDLE
    if (CE && (state_q == T3)) begin
      pend_v_d = 1'b0;
      if (PC_WR)         pc_d = PC_D;
      else if (pend_v_q) pc_d = pend_q;
    end else if (PC_WR) begin
      if ((state_q == IDLE) && !(CE && REQ)) begin
        pc_d = PC_D;
      end else begin
        pend_d   = PC_D;
        pend_v_d = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      a_q      <= '0;
      dout_q   <= '0;
      oe_q     <= 1'b0;
      rdb_q    <= 1'b1;
      wrb_q    <= 1'b1;
      csb_q    <= 1'b1;
      rdata_q  <= '0;
      t3_hit_q <= 1'b0;
      ack_q    <= 1'b0;
      pc_q     <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      oe_q     <= oe_d;
      rdb_q    <= rdb_d;
      wrb_q    <= wrb_d;
      csb_q    <= csb_d;
      rdata_q  <= rdata_d;
      t3_hit_q <= t3_hit_d;
      ack_q    <= ack_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  assign A       = a_q;
  assign DB_O    = dout_q;
  assign DB_OE   = oe_q;
  assign RDB     = rdb_q;
  assign WRB     = wrb_q;
  assign CSB     = csb_q;
  assign ACK     = ack_q;
  assign RD_DATA = rdata_q;
  assign PC      = pc_q;

endmodule

// File: tb/tb_cart_bus_master.sv
// Self-checking bench for cart_bus_master: a transaction-level model predicts
// every output each cycle; directed scenarios pin literal values.
module tb_cart_bus_master;

  logic        CLK = 1'b0;
  logic        RESB = 1'b0;
  logic        CE = 1'b0;
  logic [1:0]  WAIT_N = 2'd0;
  logic        REQ = 1'b0;
  logic        REQ_WR = 1'b0;
  logic [14:0] REQ_A = '0;
  logic [7:0]  REQ_D = '0;
  logic        ACK;
  logic [7:0]  RD_DATA;
  logic        PC_WR = 1'b0;
  logic [1:0]  PC_D = '0;
  logic [14:0] A;
  logic [7:0]  DB_O;
  logic        DB_OE;
  logic [7:0]  DB_I = '0;
  logic        RDB, WRB, CSB;
  logic [6:5]  PC;

  cart_bus_master dut (
    .CLK(CLK), .RESB(RESB), .CE(CE), .WAIT_N(WAIT_N),
    .REQ(REQ), .REQ_WR(REQ_WR), .REQ_A(REQ_A), .REQ_D(REQ_D),
    .ACK(ACK), .RD_DATA(RD_DATA), .PC_WR(PC_WR), .PC_D(PC_D),
    .A(A), .DB_O(DB_O), .DB_OE(DB_OE), .DB_I(DB_I),
    .RDB(RDB), .WRB(WRB), .CSB(CSB), .PC(PC)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: position in the cycle is the count of CE edges
  // since the request was accepted (1=T1, 2..2+w=strobe, 3+w=T3).
  int          edge_no = 0;
  int          ack_edge = -1;
  bit          m_busy, m_wr, m_pv, e_ack;
  int          m_n, m_w;
  logic [14:0] e_a;
  logic [7:0]  e_do, e_rd;
  logic [1:0]  e_pc, m_pp;
  bit          leave_idle, enter_idle;

  always @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      m_busy = 0; m_wr = 0; m_pv = 0; e_ack = 0; m_n = 0; m_w = 0;
      e_a = '0; e_do = '0; e_rd = '0; e_pc = '0; m_pp = '0; ack_edge = -1;
    end else begin
      edge_no++;
      e_ack = (edge_no == ack_edge);
      leave_idle = CE && !m_busy && REQ;
      enter_idle = CE && m_busy && (m_n == 3 + m_w);
      if (enter_idle) begin
        if (PC_WR) e_pc = PC_D;
        else if (m_pv) e_pc = m_pp;
        m_pv = 0;
      end else if (PC_WR) begin
        if (!m_busy && !leave_idle) e_pc = PC_D;
        else begin m_pp = PC_D; m_pv = 1; end
      end
      if (CE) begin
        if (!m_busy) begin
          if (REQ) begin
            m_busy = 1; m_n = 1; m_w = 0; m_wr = REQ_WR; e_a = REQ_A;
            if (REQ_WR) e_do = REQ_D;
          end
        end else if (enter_idle) begin
          m_busy = 0;
        end else begin
          m_n++;
          if (m_n == 2) m_w = int'(WAIT_N);
          if (m_n == 3 + m_w) begin
            ack_edge = edge_no + 1;
            if (!m_wr) e_rd = DB_I;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  bit e_strobe;
  always @(negedge CLK) begin
    if (chk_en) begin
      e_strobe = m_busy && (m_n >= 2) && (m_n <= 2 + m_w);
      chk("csb",   32'(CSB),     32'(!m_busy));
      chk("rdb",   32'(RDB),     32'(!(e_strobe && !m_wr)));
      chk("wrb",   32'(WRB),     32'(!(e_strobe && m_wr)));
      chk("db_oe", 32'(DB_OE),   32'(m_busy && m_wr));
      chk("addr",  32'(A),       32'(e_a));
      chk("db_o",  32'(DB_O),    32'(e_do));
      chk("ack",   32'(ACK),     32'(e_ack));
      chk("rdata", 32'(RD_DATA), 32'(e_rd));
      chk("pc",    32'(PC),      32'(e_pc));
    end
  end

  // Activity counters for the directed scenarios
  int cnt_csb = 0, cnt_rdb = 0, cnt_wrb = 0, cnt_oe = 0, cnt_ack = 0;
  int gap_run = 0, last_gap = 0;
  always @(negedge CLK) begin
    if (!CSB) cnt_csb++;
    if (!RDB) cnt_rdb++;
    if (!WRB) cnt_wrb++;
    if (DB_OE) cnt_oe++;
    if (ACK) cnt_ack++;
    if (CSB) gap_run++;
    else begin
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
    end
  end

  int b_csb, b_rdb, b_wrb, b_oe, b_ack;
  task automatic snap();
    b_csb = cnt_csb; b_rdb = cnt_rdb; b_wrb = cnt_wrb; b_oe = cnt_oe; b_ack = cnt_ack;
  endtask

  // CE pattern: 0 always, 1 every 4th CLK, 2 random, 3 held low
  int ce_mode = 0;
  int ce_ph = 0;
  bit rand_en = 0;

  task automatic step();
    @(negedge CLK);
    #1;
    case (ce_mode)
      0: CE = 1'b1;
      1: begin ce_ph = (ce_ph + 1) % 4; CE = (ce_ph == 0); end
      2: CE = 1'($urandom_range(0, 1));
      default: CE = 1'b0;
    endcase
    if (rand_en) begin
      WAIT_N = 2'($urandom_range(0, 3));
      DB_I   = 8'($urandom);
      PC_WR  = ($urandom_range(0, 7) == 0);
      PC_D   = 2'($urandom);
    end else begin
      PC_WR = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_txn(input bit wr, input logic [14:0] a, input logic [7:0] d);
    bit got;
    got = 0;
    REQ = 1'b1; REQ_WR = wr; REQ_A = a; REQ_D = d;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      if (ACK) got = 1;
    end
    REQ = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got, s1, s2, done;
    int nack;

    // Reset values
    settle(1);
    chk_en = 1'b1;
    settle(2);
    RESB = 1'b1;
    settle(2);
    chk("rst_csb", 32'(CSB), 32'd1);
    chk("rst_rdb", 32'(RDB), 32'd1);
    chk("rst_wrb", 32'(WRB), 32'd1);
    chk("rst_oe",  32'(DB_OE), 32'd0);
    chk("rst_a",   32'(A), 32'd0);
    chk("rst_rd",  32'(RD_DATA), 32'd0);
    chk("rst_pc",  32'(PC), 32'd0);

    // Read, no wait states
    DB_I = 8'hA5; WAIT_N = 2'd0;
    snap();
    do_txn(1'b0, 15'h1234, 8'h00);
    settle(4);
    chk("rd0_csb_len", 32'(cnt_csb - b_csb), 32'd3);
    chk("rd0_rdb_len", 32'(cnt_rdb - b_rdb), 32'd1);
    chk("rd0_ack_cnt", 32'(cnt_ack - b_ack), 32'd1);
    chk("rd0_data",    32'(RD_DATA), 32'hA5);
    chk("rd0_addr",    32'(A), 32'h1234);

    // Write, two wait states
    WAIT_N = 2'd2;
    snap();
    do_txn(1'b1, 15'h7FFF, 8'h3C);
    settle(4);
    chk("wr2_wrb_len", 32'(cnt_wrb - b_wrb), 32'd3);
    chk("wr2_csb_len", 32'(cnt_csb - b_csb), 32'd5);
    chk("wr2_oe_len",  32'(cnt_oe - b_oe), 32'd5);
    chk("wr2_ack_cnt", 32'(cnt_ack - b_ack), 32'd1);
    chk("wr2_db_o",    32'(DB_O), 32'h3C);
    chk("wr2_oe_idle", 32'(DB_OE), 32'd0);

    // REQ held across two reads, CE every 4th CLK
    ce_mode = 1; WAIT_N = 2'd0;
    snap();
    nack = 0;
    REQ = 1'b1; REQ_WR = 1'b0; REQ_A = 15'h0456;
    for (int i = 0; i < 400 && nack < 2; i++) begin
      step();
      if (ACK) nack++;
    end
    REQ = 1'b0;
    settle(12);
    chk("hold_acks", 32'(nack), 32'd2);
    chk("hold_gap",  32'(last_gap), 32'd4);

    // Bank-select writes during a cycle stay pending until IDLE entry
    ce_mode = 0;
    step();
    PC_WR = 1'b1; PC_D = 2'b11;
    step();
    step();
    chk("pc_idle_wr", 32'(PC), 32'd3);
    ce_mode = 1; WAIT_N = 2'd1;
    got = 0; s1 = 0; s2 = 0; done = 0;
    REQ = 1'b1; REQ_WR = 1'b0; REQ_A = 15'h2222;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (!got && ACK) begin got = 1; REQ = 1'b0; end
      if (!CSB) chk("pc_held", 32'(PC), 32'd3);
      if (!s1 && !RDB) begin PC_WR = 1'b1; PC_D = 2'b10; s1 = 1; end
      else if (s1 && !s2 && RDB && !CSB) begin PC_WR = 1'b1; PC_D = 2'b01; s2 = 1; end
      if (got && CSB) done = 1;
    end
    chk("pc_done", 32'(done), 32'd1);
    chk("pc_applied", 32'(PC), 32'd1);

    // Reset during TW of a write
    ce_mode = 0; WAIT_N = 2'd3;
    settle(2);
    snap();
    got = 0;
    REQ = 1'b1; REQ_WR = 1'b1; REQ_A = 15'h0777; REQ_D = 8'h99;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (!WRB) got = 1;
    end
    chk("rst_reach_t2", 32'(got), 32'd1);
    step();
    @(posedge CLK);
    #2 RESB = 1'b0; REQ = 1'b0;
    #1;
    chk("rstm_csb", 32'(CSB), 32'd1);
    chk("rstm_wrb", 32'(WRB), 32'd1);
    chk("rstm_rdb", 32'(RDB), 32'd1);
    chk("rstm_oe",  32'(DB_OE), 32'd0);
    chk("rstm_pc",  32'(PC), 32'd0);
    @(negedge CLK);
    #1 RESB = 1'b1;
    settle(20);
    chk("rstm_no_ack", 32'(cnt_ack - b_ack), 32'd0);
    chk("rstm_idle",   32'(CSB), 32'd1);

    // CE held low for 10 CLK in the middle of T2
    WAIT_N = 2'd0; DB_I = 8'h5A;
    snap();
    got = 0;
    REQ = 1'b1; REQ_WR = 1'b0; REQ_A = 15'h0ABC;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (!RDB) got = 1;
    end
    chk("frz_reach_t2", 32'(got), 32'd1);
    ce_mode = 3; CE = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_rdb", 32'(RDB), 32'd0);
      chk("frz_csb", 32'(CSB), 32'd0);
    end
    ce_mode = 0; CE = 1'b1;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (ACK) got = 1;
    end
    REQ = 1'b0;
    settle(4);
    chk("frz_ack",     32'(got), 32'd1);
    chk("frz_rdb_len", 32'(cnt_rdb - b_rdb), 32'd11);
    chk("frz_data",    32'(RD_DATA), 32'h5A);

    // Randomized traffic with random CE, wait states and bank writes
    ce_mode = 2; rand_en = 1;
    for (int t = 0; t < 40; t++) begin
      do_txn(1'($urandom_range(0, 1)), 15'($urandom), 8'($urandom));
      settle($urandom_range(0, 3));
    end
    rand_en = 0; ce_mode = 0;
    settle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
